// File: rtl/i2s_rx_deserializer.sv
// Philips-I2S receiver: oversamples sclk/lrclk/sdata on aud_mclk, recovers left/right words
// and queues them in a small FIFO behind a valid/ready stream.
module i2s_rx_deserializer #(
    parameter  int unsigned DATA_WIDTH = 24,
    parameter  int unsigned FIFO_DEPTH = 4,
    parameter  int unsigned ERR_CNT_W  = 8,
    localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  aud_mclk,
    input  logic                  aud_mrstn,
    input  logic                  en,
    input  logic                  sclk_in,
    input  logic                  lrclk_in,
    input  logic                  sdata_in,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tuser,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  overflow,
    input  logic                  ovf_clr,
    output logic [ERR_CNT_W-1:0]  frame_err_cnt,
    output logic [LVL_W-1:0]      fifo_level
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t                  state_q;
    logic [1:0]              sclk_sync_q, lrc_sync_q, sd_sync_q;
    logic                    sclk_dly_q;
    logic                    lrc_prev_q;
    logic                    chan_q;
    logic [CNT_W-1:0]        bit_cnt_q;
    logic [DATA_WIDTH-2:0]   shift_q;
    logic [ERR_CNT_W-1:0]    err_q;

    logic [DATA_WIDTH:0]     mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]        level_q, level_d;
    logic                    ovf_q, ovf_d;

    logic                    rise_c, lrc_c, sd_c, trans_c, last_bit_c;
    logic                    push_c, pop_c, full_c, wr_en_c;
    logic [DATA_WIDTH-1:0]   word_c;

    assign rise_c     = sclk_sync_q[1] & ~sclk_dly_q;
    assign lrc_c      = lrc_sync_q[1];
    assign sd_c       = sd_sync_q[1];
    assign trans_c    = rise_c && (lrc_c != lrc_prev_q);
    assign last_bit_c = (bit_cnt_q == CNT_W'(DATA_WIDTH - 1));
    assign word_c     = {shift_q, sd_c};

    assign push_c  = en && rise_c && !trans_c && (state_q == SHIFT) && last_bit_c;
    assign pop_c   = m_tvalid && m_tready;
    assign full_c  = (level_q == LVL_W'(FIFO_DEPTH));
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign wr_en_c = push_c && (!full_c || pop_c);

    // Synchronizers, edge detect and slot framing FSM
    always_ff @(posedge aud_mclk or negedge aud_mrstn) begin
        if (!aud_mrstn) begin
            state_q     <= IDLE;
            sclk_sync_q <= '0;
            lrc_sync_q  <= '0;
            sd_sync_q   <= '0;
            sclk_dly_q  <= 1'b0;
            lrc_prev_q  <= 1'b0;
            chan_q      <= 1'b0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            err_q       <= '0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], sclk_in};
            lrc_sync_q  <= {lrc_sync_q[0], lrclk_in};
            sd_sync_q   <= {sd_sync_q[0], sdata_in};
            sclk_dly_q  <= sclk_sync_q[1];
            if (rise_c) lrc_prev_q <= lrc_c;

            if (!en) begin
                state_q <= IDLE;
            end else if (rise_c) begin
                case (state_q)
                    SHIFT: begin
                        if (trans_c) begin
                            if (err_q != '1) err_q <= err_q + ERR_CNT_W'(1);
                            chan_q    <= lrc_c;
                            bit_cnt_q <= '0;
                        end else begin
                            shift_q <= word_c[DATA_WIDTH-2:0];
                            if (last_bit_c) state_q <= HOLD;
                            else            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        // IDLE and HOLD both (re)start on the one-bit delay slot
                        if (trans_c) begin
                            state_q   <= SHIFT;
                            chan_q    <= lrc_c;
                            bit_cnt_q <= '0;
                        end
                    end
                endcase
            end
        end
    end

    always_comb begin
        level_d = level_q + LVL_W'(wr_en_c) - LVL_W'(pop_c);
        ovf_d   = ovf_q;
        if (push_c && !wr_en_c) ovf_d = 1'b1;
        else if (ovf_clr)       ovf_d = 1'b0;
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge aud_mclk or negedge aud_mrstn) begin
        if (!aud_mrstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_en_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_c)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            level_q <= level_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge aud_mclk) begin
        if (wr_en_c) mem_q[wr_ptr_q] <= {chan_q, word_c};
    end

    assign m_tvalid      = (level_q != '0);
    assign m_tuser       = m_tvalid ? mem_q[rd_ptr_q][DATA_WIDTH] : 1'b0;
    assign m_tdata       = m_tvalid ? mem_q[rd_ptr_q][DATA_WIDTH-1:0] : '0;
    assign overflow      = ovf_q;
    assign frame_err_cnt = err_q;
    assign fifo_level    = level_q;

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Directed/randomized bench for i2s_rx_deserializer with a slot-level reference model.
module tb_i2s_rx_deserializer;

    localparam int unsigned DW    = 24;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned EW    = 8;
    localparam int unsigned LW    = 3;
    localparam int          ERR_MAX = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          rst_n, en, sclk, lrclk, sdata, m_tready, ovf_clr;
    logic [DW-1:0] m_tdata;
    logic          m_tuser, m_tvalid, overflow;
    logic [EW-1:0] frame_err_cnt;
    logic [LW-1:0] fifo_level;

    always #5 clk = ~clk;

    i2s_rx_deserializer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .ERR_CNT_W(EW)) dut (
        .aud_mclk(clk), .aud_mrstn(rst_n), .en(en),
        .sclk_in(sclk), .lrclk_in(lrclk), .sdata_in(sdata),
        .m_tdata(m_tdata), .m_tuser(m_tuser), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .overflow(overflow), .ovf_clr(ovf_clr),
        .frame_err_cnt(frame_err_cnt), .fifo_level(fifo_level)
    );

    int            checks = 0;
    int            errors = 0;
    logic [DW:0]   exp_q[$];
    int            err_exp = 0;
    bit            ovf_exp = 0;
    bit            last_lr = 0;
    bit            started = 0;
    bit            pending_short = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Receiver model: a slot is received when it opens with an lrclk change while enabled;
    // an opened slot too short for a word is counted when the next change arrives.
    function automatic void model_slot_start(input bit ch, input int len);
        bit trans;
        trans   = (ch != last_lr);
        last_lr = ch;
        if (trans && en) begin
            if (pending_short && err_exp < ERR_MAX) err_exp++;
            pending_short = 0;
            started       = 1;
            if (len - 1 < int'(DW)) pending_short = 1;
        end
    endfunction

    function automatic void model_push(input bit ch, input logic [DW-1:0] w);
        if (exp_q.size() < DEPTH) exp_q.push_back({ch, w});
        else                      ovf_exp = 1;
        started = 0;
    endfunction

    task automatic sbit(input bit lr, input bit d, input int half, input bit pop);
        @(posedge clk); #1;
        sclk = 0; lrclk = lr; sdata = d;
        repeat (half) @(posedge clk);
        #1 sclk = 1;
        if (pop) begin
            // Hold ready for exactly the cycle in which this bit's word is pushed.
            @(posedge clk); @(posedge clk); #1 m_tready = 1;
            @(posedge clk); #1 m_tready = 0;
            repeat (half - 4) @(posedge clk);
        end else begin
            repeat (half - 1) @(posedge clk);
        end
    endtask

    task automatic slot(input int len, input logic [DW-1:0] w, input int half,
                        input bit pop, input int en_drop);
        bit ch;
        ch = !last_lr;
        for (int k = 0; k < len; k++) begin
            bit b;
            if (k >= 1 && k <= int'(DW)) b = w[DW-k];
            else                         b = 1'($urandom);
            if (k == en_drop) begin
                @(posedge clk); #1 en = 0;
                started = 0; pending_short = 0;
            end
            if (k == 0) model_slot_start(ch, len);
            sbit(ch, b, half, pop && (k == int'(DW)));
            if (k == int'(DW) && started && len - 1 >= int'(DW)) model_push(ch, w);
        end
    endtask

    task automatic drain(input string tag);
        int n;
        @(posedge clk); #1 m_tready = 1;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk); n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_level"}, 32'(fifo_level), 32'd0);
        chk({tag, "_tvalid"}, 32'(m_tvalid), 32'd0);
    endtask

    initial begin
        rst_n = 0; en = 0; sclk = 0; lrclk = 0; sdata = 0; m_tready = 0; ovf_clr = 0;

        // Beat monitor: every transfer must match the head of the model queue.
        fork
            forever begin : mon
                logic [DW:0] e;
                @(negedge clk);
                if (rst_n && m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $error("FAIL beat_unexpected: observed %0h expected none", {m_tuser, m_tdata});
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat", 32'({m_tuser, m_tdata}), 32'(e));
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_errcnt", 32'(frame_err_cnt), 32'd0);
        chk("rst_tdata", 32'(m_tdata), 32'd0);
        rst_n = 1;
        @(posedge clk); #1 en = 1; m_tready = 1;

        // Basic stereo: a right slot to sync, then L = A5A5A5, R = 5A5A5A
        slot(32, DW'($urandom), 4, 0, -1);
        slot(32, 24'hA5A5A5, 4, 0, -1);
        slot(32, 24'h5A5A5A, 4, 0, -1);
        drain("stereo");
        chk("stereo_errcnt", 32'(frame_err_cnt), 32'(err_exp));

        // Back-pressure: six samples into a four-entry FIFO
        @(posedge clk); #1 m_tready = 0;
        for (int i = 0; i < 6; i++) slot(32, DW'($urandom), 4, 0, -1);
        chk("bp_level", 32'(fifo_level), 32'(exp_q.size()));
        chk("bp_level_full", 32'(fifo_level), 32'(DEPTH));
        chk("bp_overflow", 32'(overflow), 32'(ovf_exp));
        drain("bp");
        @(posedge clk); #1 ovf_clr = 1;
        @(posedge clk); #1 ovf_clr = 0; ovf_exp = 0;
        chk("ovf_clr", 32'(overflow), 32'(ovf_exp));

        // Full FIFO with push and pop in the same cycle
        m_tready = 0;
        for (int i = 0; i < 4; i++) slot(32, DW'($urandom), 4, 0, -1);
        chk("full_level", 32'(fifo_level), 32'(DEPTH));
        slot(32, DW'($urandom), 4, 1, -1);
        chk("fullpop_level", 32'(fifo_level), 32'(exp_q.size()));
        chk("fullpop_overflow", 32'(overflow), 32'(ovf_exp));
        drain("fullpop");

        // Enable dropped mid-word, two slots disabled, then a complete slot
        slot(32, DW'($urandom), 4, 0, 10);
        slot(32, DW'($urandom), 4, 0, -1);
        slot(32, DW'($urandom), 4, 0, -1);
        @(posedge clk); #1 en = 1;
        slot(32, DW'($urandom), 4, 0, -1);
        drain("en_toggle");
        chk("en_errcnt", 32'(frame_err_cnt), 32'(err_exp));

        // Short frames: 16-bit slots never complete a 24-bit word
        for (int i = 0; i < 4; i++) slot(16, DW'($urandom), 2, 0, -1);
        chk("short_errcnt", 32'(frame_err_cnt), 32'(err_exp));
        for (int i = 0; i < 256; i++) slot(16, DW'($urandom), 2, 0, -1);
        chk("short_errcnt_sat", 32'(frame_err_cnt), 32'(err_exp));
        chk("short_no_beats", 32'(fifo_level), 32'd0);

        // Asynchronous reset mid-frame with two samples queued
        m_tready = 0;
        slot(32, DW'($urandom), 4, 0, -1);
        slot(32, DW'($urandom), 4, 0, -1);
        chk("prereset_level", 32'(fifo_level), 32'(exp_q.size()));
        model_slot_start(!last_lr, 32);
        for (int k = 0; k < 6; k++) sbit(last_lr, 1'($urandom), 4, 0);
        @(posedge clk); #2 rst_n = 0;
        #1;
        chk("arst_tvalid", 32'(m_tvalid), 32'd0);
        chk("arst_level", 32'(fifo_level), 32'd0);
        chk("arst_overflow", 32'(overflow), 32'd0);
        chk("arst_errcnt", 32'(frame_err_cnt), 32'd0);
        exp_q.delete();
        err_exp = 0; ovf_exp = 0; started = 0; pending_short = 0; last_lr = 0;
        sclk = 0; lrclk = 0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1; m_tready = 1;
        slot(32, DW'($urandom), 4, 0, -1);
        slot(32, DW'($urandom), 4, 0, -1);
        drain("post_reset");
        chk("post_reset_errcnt", 32'(frame_err_cnt), 32'(err_exp));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
